// File: rtl/pingpong_framebuf.sv
// Double-buffered frame store: the writer fills the back bank while the reader scans the front bank.
// Banks exchange only on a reader vsync after the writer has declared its frame complete.
module pingpong_framebuf #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr_done,
    input  logic              rd,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rd_vsync,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              rd_bank,
    output logic              swap_pending,
    output logic              ready_wr,
    output logic [CNT_W-1:0]  overrun_cnt
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] bank0 [Depth];
    logic [DATA_W-1:0] bank1 [Depth];

    logic sel_q;
    logic pending_q;
    logic wr_en;

    assign rd_bank      = sel_q;
    assign swap_pending = pending_q;
    assign ready_wr     = ~pending_q;

    // A completed frame is frozen until the swap consumes it.
    assign wr_en = wr && !pending_q && !rst;

    // Storage carries no reset so each bank maps onto a plain block RAM.
    always_ff @(negedge clk) begin
        if (wr_en && sel_q) begin
            bank0[waddr] <= wdata;
        end
    end

    always_ff @(negedge clk) begin
        if (wr_en && !sel_q) begin
            bank1[waddr] <= wdata;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else if (rd) begin
            rdata       <= sel_q ? bank1[raddr] : bank0[raddr];
            rdata_valid <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            sel_q       <= 1'b0;
            pending_q   <= 1'b0;
            overrun_cnt <= '0;
        end else if (pending_q) begin
            // A second frame completion before the swap loses a frame.
            if (wr_done && (overrun_cnt != {CNT_W{1'b1}})) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
            if (rd_vsync) begin
                sel_q     <= ~sel_q;
                pending_q <= 1'b0;
            end
        end else if (wr_done) begin
            pending_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pingpong_framebuf.sv
// Self-checking bench for pingpong_framebuf: directed vector table, saturation sequence,
// and randomized traffic compared against a frame-level reference model.
module tb_pingpong_framebuf;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b1;
    logic              rst = 1'b0;
    logic              wr = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              wr_done = 1'b0;
    logic              rd = 1'b0;
    logic [ADDR_W-1:0] raddr = '0;
    logic              rd_vsync = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              rd_bank;
    logic              swap_pending;
    logic              ready_wr;
    logic [CNT_W-1:0]  overrun_cnt;

    int checks = 0;
    int failures = 0;

    pingpong_framebuf #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .waddr       (waddr),
        .wdata       (wdata),
        .wr_done     (wr_done),
        .rd          (rd),
        .raddr       (raddr),
        .rd_vsync    (rd_vsync),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rd_bank     (rd_bank),
        .swap_pending(swap_pending),
        .ready_wr    (ready_wr),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              wr;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              done;
        logic              rd;
        logic [ADDR_W-1:0] ra;
        logic              vs;
        logic [DATA_W-1:0] e_rdata;
        logic              e_valid;
        logic              e_bank;
        logic              e_pend;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic w, input int wa, input int wd,
                                input logic dn, input logic rr, input int ra, input logic vs,
                                input int er, input logic ev, input logic eb, input logic ep,
                                input int ec);
        vec_t v;
        v.rst = r; v.wr = w; v.wa = ADDR_W'(wa); v.wd = DATA_W'(wd);
        v.done = dn; v.rd = rr; v.ra = ADDR_W'(ra); v.vs = vs;
        v.e_rdata = DATA_W'(er); v.e_valid = ev; v.e_bank = eb; v.e_pend = ep;
        v.e_cnt = CNT_W'(ec);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic dn, input logic rr,
                         input logic [ADDR_W-1:0] ra, input logic vs);
        rst = r; wr = w; waddr = wa; wdata = wd; wr_done = dn; rd = rr; raddr = ra;
        rd_vsync = vs;
    endtask

    // State changes on the falling edge; sample 1 time unit later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model state: banks as plain arrays plus frame-level flags.
    logic [DATA_W-1:0] m_mem [2][16];
    bit                m_known [2][16];
    logic              m_sel, m_pend, m_valid;
    logic [DATA_W-1:0] m_rdata;
    bit                m_rknown;
    int                m_cnt;

    task automatic model_step(input logic r, input logic w, input int wa, input logic [DATA_W-1:0] wd,
                              input logic dn, input logic rr, input int ra, input logic vs);
        if (r) begin
            m_sel = 0; m_pend = 0; m_rdata = '0; m_rknown = 1; m_valid = 0; m_cnt = 0;
            return;
        end
        if (rr) begin
            m_rdata  = m_mem[m_sel][ra];
            m_rknown = m_known[m_sel][ra];
        end
        m_valid = rr;
        if (w && !m_pend) begin
            m_mem[!m_sel][wa]   = wd;
            m_known[!m_sel][wa] = 1;
        end
        if (m_pend) begin
            if (dn) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (vs) begin
                m_sel  = !m_sel;
                m_pend = 0;
            end
        end else if (dn) begin
            m_pend = 1;
        end
    endtask

    initial begin
        // Directed table: rst wr wa wd done rd ra vs | rdata valid bank pend cnt
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, i, 'hAA0000 + i, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, i, 0,  'hAA0000 + i, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  'hAA0003, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h550000, 0, 0, 0, 0,  'hAA0003, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  'hAA0003, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  'hAA0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  'hAA0000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 'h123456, 0, 0, 0, 0,  'hAA0000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  'hAA0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  'h550000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1,  'h550000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1,  'h550000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  'hAA0000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  'hAA0000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  'hAA0000, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1,  'hAA0000, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  'hAA0000, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 'h000777, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 0,  'h000777, 1, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].done, tbl[i].rd,
                  tbl[i].ra, tbl[i].vs);
            tick();
            check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].e_rdata));
            check($sformatf("vec%0d rdata_valid", i), 32'(rdata_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d rd_bank", i), 32'(rd_bank), 32'(tbl[i].e_bank));
            check($sformatf("vec%0d swap_pending", i), 32'(swap_pending), 32'(tbl[i].e_pend));
            check($sformatf("vec%0d ready_wr", i), 32'(ready_wr), 32'(!tbl[i].e_pend));
            check($sformatf("vec%0d overrun_cnt", i), 32'(overrun_cnt), 32'(tbl[i].e_cnt));
        end

        // Saturation: first pulse sets pending, the next 300 are overruns.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 301; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0);
            tick();
            if (i == 254) check("sat cnt at 254 overruns", 32'(overrun_cnt), 32'd254);
            if (i == 255) check("sat cnt at 255 overruns", 32'(overrun_cnt), 32'd255);
        end
        check("sat cnt after 300 overruns", 32'(overrun_cnt), 32'd255);
        check("sat pending held", 32'(swap_pending), 32'd1);
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        tick();
        check("sat swap with overrun", 32'(rd_bank), 32'd1);
        check("sat cnt stays", 32'(overrun_cnt), 32'd255);

        // Randomized traffic against the reference model.
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 16; a++) m_known[b][a] = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        model_step(1, 0, 0, '0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, w, dn, rr, vs;
            int wa, ra;
            logic [DATA_W-1:0] wd;
            r  = ($urandom_range(0, 199) == 0);
            w  = $urandom_range(0, 1);
            wa = $urandom_range(0, 15);
            wd = DATA_W'($urandom);
            dn = ($urandom_range(0, 7) == 0);
            rr = $urandom_range(0, 1);
            ra = $urandom_range(0, 15);
            vs = ($urandom_range(0, 5) == 0);
            drive(r, w, ADDR_W'(wa), wd, dn, rr, ADDR_W'(ra), vs);
            tick();
            model_step(r, w, wa, wd, dn, rr, ra, vs);
            check("rnd rdata_valid", 32'(rdata_valid), 32'(m_valid));
            check("rnd rd_bank", 32'(rd_bank), 32'(m_sel));
            check("rnd swap_pending", 32'(swap_pending), 32'(m_pend));
            check("rnd ready_wr", 32'(ready_wr), 32'(!m_pend));
            check("rnd overrun_cnt", 32'(overrun_cnt), 32'(m_cnt));
            if (m_rknown) check("rnd rdata", 32'(rdata), 32'(m_rdata));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
